// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher: one round per clock, 11 cycles per block.
// Uses the externally held 1408-bit key schedule; it is not captured locally.
module aes_decryption (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            key_valid,
  input  logic [0:127]    cipher_in,
  input  logic [0:1407]   key_schedule,
  output logic            busy,
  output logic            done,
  output logic [0:127]    plain_out
);

  typedef enum logic {StIdle, StRun} fsm_e;

  // Inverse S-box ROM; byte x lives at bits [8x +: 8].
  localparam logic [0:2047] InvSboxRom = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return InvSboxRom[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Column multiply by circulant {0e,0b,0d,09}; col[31:24] is row 0.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  fsm_e         r_fsm;
  logic [0:127] r_state;
  logic [3:0]   r_round;
  logic [0:127] r_plain;
  logic         r_done;

  fsm_e         w_fsm_d;
  logic [0:127] w_state_d;
  logic [3:0]   w_round_d;
  logic [0:127] w_plain_d;
  logic         w_done_d;

  logic [0:127] w_inv_sb;
  logic [0:127] w_rk;
  logic [0:127] w_add;
  logic [0:127] w_mix;

  // InvShiftRows folded into the S-box input select: out[r][c] = in[r][(c-r) mod 4].
  always_comb begin
    w_inv_sb = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_inv_sb[8*(4*c+r) +: 8] = inv_sbox(r_state[8*(4*((c-r+4)%4)+r) +: 8]);
      end
    end
  end

  assign w_rk  = key_schedule[128*r_round +: 128];
  assign w_add = w_inv_sb ^ w_rk;

  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      w_mix[32*c +: 32] = inv_mix_col(w_add[32*c +: 32]);
    end
  end

  always_comb begin
    w_fsm_d   = r_fsm;
    w_state_d = r_state;
    w_round_d = r_round;
    w_plain_d = r_plain;
    w_done_d  = 1'b0;
    unique case (r_fsm)
      StIdle: begin
        if (start && key_valid) begin
          w_state_d = cipher_in ^ key_schedule[1280 +: 128];
          w_round_d = 4'd9;
          w_fsm_d   = StRun;
        end
      end
      StRun: begin
        if (r_round != 4'd0) begin
          w_state_d = w_mix;
          w_round_d = r_round - 4'd1;
        end else begin
          w_state_d = w_add;
          w_plain_d = w_add;
          w_done_d  = 1'b1;
          w_fsm_d   = StIdle;
        end
      end
      default: w_fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= StIdle;
      r_state <= '0;
      r_round <= '0;
      r_plain <= '0;
      r_done  <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_d;
      r_state <= w_state_d;
      r_round <= w_round_d;
      r_plain <= w_plain_d;
      r_done  <= w_done_d;
    end
  end

  assign busy      = (r_fsm == StRun);
  assign done      = r_done;
  assign plain_out = r_plain;

endmodule
